lpc_postcode_hist: RTL and testbench

- Parametrised successor to the single-port POST code latch, serving the LPC_Peri backend bus.
- Captures host I/O writes to NPORTS consecutive POST ports starting at BASE_ADDR and keeps the latest byte per port.
- Pushes every port-0 code into a DEPTH-entry history FIFO that the host or BMC drains through a pop/status port pair at HIST_ADDR.
- Drives the active-low front-panel LED bar with the latest port-0 code.

---
 rtl/lpc_postcode_hist_pkg.sv | 13 +
 rtl/lpc_postcode_hist_if.sv | 12 +
 rtl/lpc_postcode_hist_fifo.sv | 47 ++++
 rtl/lpc_postcode_hist.sv | 80 ++++++++
 tb/tb_lpc_postcode_hist.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/lpc_postcode_hist_pkg.sv
// lpc_pkg: shared LPC addresses, status/control bit positions and helpers.
package lpc_pkg;
    localparam logic [15:0] LPC_POST_ADD = 16'h0080;
    localparam logic [15:0] LPC_COM0_ADD = 16'h03F8;
    localparam int ST_OVF = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_FULL = 5;
    localparam int ST_CNT_MSB = 4;
    localparam int CTRL_CLR = 0;
    function automatic logic [4:0] sat_cnt(input logic [6:0] c);
        return c > 7'd31 ? 5'd31 : c[4:0];
    endfunction
endpackage

// File: rtl/lpc_postcode_hist_if.sv
// lpc_postcode_hist_if: LPC_Peri backend bus as seen by an I/O peripheral.
interface lpc_postcode_hist_if;
    logic        lpc_en;
    logic [15:0] lpc_addr;
    logic [7:0]  lpc_wdata;
    logic        io_wren;
    logic        io_rden;
    logic        addr_hit;
    logic [7:0]  rdata;
    modport master (output lpc_en, lpc_addr, lpc_wdata, io_wren, io_rden, input addr_hit, rdata);
    modport slave (input lpc_en, lpc_addr, lpc_wdata, io_wren, io_rden, output addr_hit, rdata);
endinterface

// File: rtl/lpc_postcode_hist_fifo.sv
// postcode_fifo: synchronous history FIFO with drop-oldest or drop-newest full policy.
module postcode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter bit OVERWRITE = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic pop_ok, wr, adv;
    always_comb begin
        full = count == (AW+1)'(DEPTH);
        empty = count == '0;
        pop_ok = pop & ~empty;
        wr = push & (~full | pop_ok | OVERWRITE);
        // a full overwrite retires the oldest entry so count stays at DEPTH
        adv = pop_ok | (push & full & ~pop_ok & OVERWRITE);
        dout = mem[rptr];
    end
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (adv) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(adv);
            if (push & full & ~pop_ok) ovf <= 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= din;
endmodule

// File: rtl/lpc_postcode_hist.sv
// lpc_postcode_hist: multi-port POST code capture with history FIFO and LED bar drive.
module lpc_postcode_hist
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = LPC_POST_ADD,
    parameter int NPORTS = 2,
    parameter int DEPTH = 16,
    parameter logic [15:0] HIST_ADDR = 16'h0084,
    parameter bit OVERWRITE = 1,
    parameter bit DEDUP = 0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                lclk,
    input  logic                lreset,
    lpc_postcode_hist_if.slave  bus,
    output logic [8*NPORTS-1:0] postcode,
    output logic [7:0]          seg7_led,
    output logic [CW-1:0]       hist_count,
    output logic                hist_ovf
);
    logic wr_q, rd_q, wr_blk, rd_blk, wr_ev, rd_ev;
    logic port_hit, hist_hit, stat_hit, push, pop, clr, accept, full, empty, last_vld;
    logic [15:0] off;
    logic [1:0] idx;
    logic [7:0] last, dout, status, rd_mux;
    always_comb begin
        off = bus.lpc_addr - BASE_ADDR;
        idx = off[1:0];
        port_hit = off < 16'(NPORTS);
        hist_hit = bus.lpc_addr == HIST_ADDR;
        stat_hit = bus.lpc_addr == HIST_ADDR + 16'd1;
        bus.addr_hit = port_hit | hist_hit | stat_hit;
        wr_ev = bus.lpc_en & bus.io_wren & ~wr_q & ~wr_blk;
        rd_ev = bus.lpc_en & bus.io_rden & ~rd_q & ~rd_blk;
        push = wr_ev & port_hit & (idx == 2'd0) & ~(DEDUP & last_vld & (last == bus.lpc_wdata));
        pop = rd_ev & hist_hit;
        clr = wr_ev & stat_hit & bus.lpc_wdata[CTRL_CLR];
        accept = push & (~full | pop | OVERWRITE);
        status = '0;
        status[ST_OVF] = hist_ovf;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_CNT_MSB:0] = sat_cnt(7'(hist_count));
        rd_mux = hist_hit ? (empty ? 8'hFF : dout) : stat_hit ? status : postcode[8*idx +: 8];
        seg7_led = ~postcode[7:0];
    end
    // *_blk masks a strobe that was already high across reset until it drops
    always_ff @(posedge lclk) begin
        wr_q <= ~lreset & bus.io_wren;
        rd_q <= ~lreset & bus.io_rden;
        wr_blk <= lreset ? bus.io_wren : wr_blk & bus.io_wren;
        rd_blk <= lreset ? bus.io_rden : rd_blk & bus.io_rden;
        if (lreset) begin
            postcode <= '0;
            bus.rdata <= 8'hFF;
            last <= '0;
            last_vld <= 1'b0;
        end else begin
            if (wr_ev & port_hit) postcode[8*idx +: 8] <= bus.lpc_wdata;
            if (rd_ev & bus.addr_hit) bus.rdata <= rd_mux;
            if (accept) begin
                last <= bus.lpc_wdata;
                last_vld <= 1'b1;
            end
        end
    end
    postcode_fifo #(.WIDTH(8), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
        .clk(lclk),
        .rst(lreset),
        .push(push),
        .pop(pop),
        .clr(clr),
        .din(bus.lpc_wdata),
        .dout(dout),
        .count(hist_count),
        .full(full),
        .empty(empty),
        .ovf(hist_ovf)
    );
endmodule

// File: tb/tb_lpc_postcode_hist.sv
// tb_lpc_postcode_hist: scoreboard bench over default, drop-new and dedup instances.
module tb_lpc_postcode_hist;
    logic clk = 0, rst = 1, en = 0, wren = 0, rden = 0;
    logic [15:0] addr = 0;
    logic [7:0] wdata = 0;
    int sel = 0;
    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [15:0] pc0, pc1, pc2, pcs;
    logic [7:0] seg0, seg1, seg2, rds;
    logic [4:0] cnt0, cnt1, cnt2, cnts;
    logic ovf0, ovf1, ovf2, ovfs;
    lpc_postcode_hist_if b0 ();
    lpc_postcode_hist_if b1 ();
    lpc_postcode_hist_if b2 ();
    always #5 clk = ~clk;
    assign b0.lpc_en = en && sel == 0;
    assign b1.lpc_en = en && sel == 1;
    assign b2.lpc_en = en && sel == 2;
    assign {b0.lpc_addr, b1.lpc_addr, b2.lpc_addr} = {3{addr}};
    assign {b0.lpc_wdata, b1.lpc_wdata, b2.lpc_wdata} = {3{wdata}};
    assign {b0.io_wren, b1.io_wren, b2.io_wren} = {3{wren}};
    assign {b0.io_rden, b1.io_rden, b2.io_rden} = {3{rden}};
    assign pcs = sel == 0 ? pc0 : sel == 1 ? pc1 : pc2;
    assign rds = sel == 0 ? b0.rdata : sel == 1 ? b1.rdata : b2.rdata;
    assign cnts = sel == 0 ? cnt0 : sel == 1 ? cnt1 : cnt2;
    assign ovfs = sel == 0 ? ovf0 : sel == 1 ? ovf1 : ovf2;
    lpc_postcode_hist u0 (.lclk(clk), .lreset(rst), .bus(b0), .postcode(pc0), .seg7_led(seg0), .hist_count(cnt0), .hist_ovf(ovf0));
    lpc_postcode_hist #(.OVERWRITE(0)) u1 (.lclk(clk), .lreset(rst), .bus(b1), .postcode(pc1), .seg7_led(seg1), .hist_count(cnt1), .hist_ovf(ovf1));
    lpc_postcode_hist #(.DEDUP(1)) u2 (.lclk(clk), .lreset(rst), .bus(b2), .postcode(pc2), .seg7_led(seg2), .hist_count(cnt2), .hist_ovf(ovf2));

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1 en = 1; wren = 1; addr = a; wdata = d;
        @(posedge clk); #1 en = 0; wren = 0;
    endtask
    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(posedge clk); #1 en = 1; rden = 1; addr = a;
        @(posedge clk); #1 en = 0; rden = 0; d = rds;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++; if (pc0 !== 16'h0) begin failures++; $display("FAIL reset_postcode got=%h exp=0000", pc0); end
        checks++; if (seg0 !== 8'hFF) begin failures++; $display("FAIL reset_seg7 got=%h exp=ff", seg0); end
        checks++; if (b0.rdata !== 8'hFF) begin failures++; $display("FAIL reset_rdata got=%h exp=ff", b0.rdata); end
        checks++; if (cnt0 !== 5'd0 || ovf0 !== 1'b0) begin failures++; $display("FAIL reset_fifo cnt=%0d ovf=%b exp 0/0", cnt0, ovf0); end
    endtask

    task automatic test_basic;
        logic [7:0] d, e;
        logic [7:0] codes[3] = '{8'h12, 8'h34, 8'h56};
        sel = 0; exp_q.delete();
        foreach (codes[i]) begin wr(16'h0080, codes[i]); exp_q.push_back(codes[i]); end
        checks++; if (pc0[7:0] !== 8'h56) begin failures++; $display("FAIL basic_postcode got=%h exp=56", pc0[7:0]); end
        checks++; if (seg0 !== 8'hA9) begin failures++; $display("FAIL basic_seg7 got=%h exp=a9", seg0); end
        checks++; if (cnt0 !== 5'(exp_q.size())) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", cnt0, exp_q.size()); end
        for (int i = 0; i < 4; i++) begin
            rd(16'h0084, d);
            e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hFF;
            checks++; if (d !== e) begin failures++; $display("FAIL basic_pop%0d got=%h exp=%h", i, d, e); end
        end
    endtask

    task automatic test_port1;
        logic [15:0] at[6] = '{16'h0080, 16'h0081, 16'h0082, 16'h0084, 16'h0085, 16'h03F8};
        logic eh[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sel = 0;
        wr(16'h0081, 8'hAB);
        checks++; if (pc0 !== 16'hAB56) begin failures++; $display("FAIL port1_postcode got=%h exp=ab56", pc0); end
        checks++; if (cnt0 !== 5'd0) begin failures++; $display("FAIL port1_count got=%0d exp=0", cnt0); end
        foreach (at[i]) begin
            addr = at[i]; #1;
            checks++; if (b0.addr_hit !== eh[i]) begin failures++; $display("FAIL addr_hit_%h got=%b exp=%b", at[i], b0.addr_hit, eh[i]); end
        end
    endtask

    task automatic test_overflow(input int s, input bit ow);
        logic [7:0] d, e;
        sel = s; exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            wr(16'h0080, 8'(i));
            if (exp_q.size() < 16) exp_q.push_back(8'(i));
            else if (ow) begin void'(exp_q.pop_front()); exp_q.push_back(8'(i)); end
        end
        checks++; if (cnts !== 5'd16 || ovfs !== 1'b1) begin failures++; $display("FAIL ovf%0d_state cnt=%0d ovf=%b exp 16/1", s, cnts, ovfs); end
        checks++; if (pcs[7:0] !== 8'h11) begin failures++; $display("FAIL ovf%0d_postcode got=%h exp=11", s, pcs[7:0]); end
        for (int i = 0; i < 2; i++) begin
            rd(16'h0085, d);
            checks++; if (d !== 8'hB0) begin failures++; $display("FAIL ovf%0d_status%0d got=%h exp=b0", s, i, d); end
        end
        rd(16'h0084, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL ovf%0d_first_pop got=%h exp=%h", s, d, e); end
        wr(16'h0085, 8'h01);
        exp_q.delete();
        rd(16'h0085, d);
        checks++; if (d !== 8'h40 || cnts !== 5'd0 || ovfs !== 1'b0) begin failures++; $display("FAIL ovf%0d_clear status=%h cnt=%0d ovf=%b exp 40/0/0", s, d, cnts, ovfs); end
    endtask

    task automatic test_dedup;
        logic [7:0] d, e, lst;
        logic vld = 0;
        logic [7:0] codes[4] = '{8'h33, 8'h33, 8'h44, 8'h33};
        sel = 2; exp_q.delete();
        foreach (codes[i]) begin
            wr(16'h0080, codes[i]);
            if (!(vld && lst == codes[i])) begin exp_q.push_back(codes[i]); lst = codes[i]; vld = 1; end
        end
        checks++; if (cnt2 !== 5'(exp_q.size())) begin failures++; $display("FAIL dedup_count got=%0d exp=%0d", cnt2, exp_q.size()); end
        while (exp_q.size() != 0) begin
            rd(16'h0084, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL dedup_pop got=%h exp=%h", d, e); end
        end
    endtask

    task automatic test_hold;
        logic [7:0] d;
        sel = 0;
        @(posedge clk); #1 en = 1; wren = 1; addr = 16'h0080; wdata = 8'h77;
        repeat (5) @(posedge clk);
        #1 en = 0; wren = 0;
        checks++; if (cnt0 !== 5'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", cnt0); end
        rd(16'h0084, d);
        checks++; if (d !== 8'h77) begin failures++; $display("FAIL hold_pop got=%h exp=77", d); end
        wr(16'h0080, 8'h05);
        wr(16'h0084, 8'h01);
        wr(16'h0085, 8'h00);
        checks++; if (cnt0 !== 5'd1) begin failures++; $display("FAIL ctrl_noop_count got=%0d exp=1", cnt0); end
        wr(16'h0085, 8'h01);
        rd(16'h0085, d);
        checks++; if (d !== 8'h40 || cnt0 !== 5'd0 || ovf0 !== 1'b0) begin failures++; $display("FAIL ctrl_clear status=%h cnt=%0d ovf=%b exp 40/0/0", d, cnt0, ovf0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        sel = 0;
        for (int i = 1; i <= 4; i++) wr(16'h0080, 8'(i));
        checks++; if (cnt0 !== 5'd4) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=4", cnt0); end
        @(posedge clk); #1 en = 1; rden = 1; addr = 16'h0085; rst = 1;
        @(posedge clk); #1 rst = 0;
        checks++; if (pc0 !== 16'h0 || seg0 !== 8'hFF || b0.rdata !== 8'hFF || cnt0 !== 5'd0 || ovf0 !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs pc=%h seg=%h rdata=%h cnt=%0d ovf=%b", pc0, seg0, b0.rdata, cnt0, ovf0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b0.rdata !== 8'hFF) begin failures++; $display("FAIL rstmid_no_event got=%h exp=ff", b0.rdata); end
        en = 0; rden = 0;
        rd(16'h0085, d);
        checks++; if (d !== 8'h40) begin failures++; $display("FAIL rstmid_status got=%h exp=40", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_port1();
        test_overflow(0, 1'b1);
        test_overflow(1, 1'b0);
        test_dedup();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
